// File: rtl/pe_id_config_loader_if.sv
// Valid/ready config bus from the ID loader to the PE-array multicast controllers.
// The loader drives the master modport; the controllers sit on the slave side.
interface pe_id_config_loader_if #(
  parameter int unsigned XID_BITS = 5
) ();
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_type;
  logic                cfg_is_y;
  logic [2:0]          cfg_row;
  logic [2:0]          cfg_col;
  logic [XID_BITS-1:0] cfg_id;

  modport master (
    output cfg_valid, cfg_type, cfg_is_y, cfg_row, cfg_col, cfg_id,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_type, cfg_is_y, cfg_row, cfg_col, cfg_id,
    output cfg_ready
  );
endinterface

// File: rtl/pe_id_config_loader.sv
// Snapshots the four PE-array ID tables plus LN config on start, then streams every
// YID/XID entry over the config bus, publishes the LN config, and pulses done.
module pe_id_config_loader #(
  parameter int unsigned NUMS_PE_ROW = 6,
  parameter int unsigned NUMS_PE_COL = 8,
  parameter int unsigned XID_BITS    = 5,
  parameter int unsigned YID_BITS    = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*XID_BITS-1:0] filter_XID_flat,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*XID_BITS-1:0] ifmap_XID_flat,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*XID_BITS-1:0] ipsum_XID_flat,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*XID_BITS-1:0] opsum_XID_flat,
  input  logic [NUMS_PE_ROW*YID_BITS-1:0]             filter_YID_flat,
  input  logic [NUMS_PE_ROW*YID_BITS-1:0]             ifmap_YID_flat,
  input  logic [NUMS_PE_ROW*YID_BITS-1:0]             ipsum_YID_flat,
  input  logic [NUMS_PE_ROW*YID_BITS-1:0]             opsum_YID_flat,
  input  logic [4:0]                                  LN_config_in,
  pe_id_config_loader_if.master                       cfg,
  output logic [4:0]                                  ln_config_out,
  output logic                                        ln_config_valid,
  output logic                                        busy,
  output logic                                        done
);
  localparam int unsigned NumPe = NUMS_PE_ROW * NUMS_PE_COL;
  localparam int unsigned IdxW  = $clog2(NumPe);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSendY = 3'd1;
  localparam logic [2:0] StSendX = 3'd2;
  localparam logic [2:0] StLn    = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [2:0] LastRow = 3'(NUMS_PE_ROW - 1);
  localparam logic [2:0] LastCol = 3'(NUMS_PE_COL - 1);

  logic [2:0]          state_q;
  logic [1:0]          type_q;
  logic [2:0]          row_q;
  logic [2:0]          col_q;
  logic [4:0]          ln_snap_q;
  logic [XID_BITS-1:0] x_snap_q [4][NumPe];
  logic [YID_BITS-1:0] y_snap_q [4][NUMS_PE_ROW];

  logic            sending;
  logic            hs;
  logic [IdxW-1:0] pe_idx;

  always_comb begin
    sending = (state_q == StSendY) || (state_q == StSendX);
    hs      = sending && cfg.cfg_ready;
    pe_idx  = IdxW'(row_q) * IdxW'(NUMS_PE_COL) + IdxW'(col_q);

    // Payload comes straight from registered state and the snapshot, so it is stable
    // for as long as a stalled transfer waits.
    cfg.cfg_valid = sending;
    cfg.cfg_is_y  = (state_q == StSendY);
    cfg.cfg_type  = sending ? type_q : 2'd0;
    cfg.cfg_row   = sending ? row_q : 3'd0;
    cfg.cfg_col   = (state_q == StSendX) ? col_q : 3'd0;
    cfg.cfg_id    = '0;
    if (state_q == StSendY) begin
      cfg.cfg_id = XID_BITS'(y_snap_q[type_q][row_q]);
    end else if (state_q == StSendX) begin
      cfg.cfg_id = x_snap_q[type_q][pe_idx];
    end

    ln_config_valid = (state_q == StLn);
    busy            = sending || (state_q == StLn);
    done            = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      type_q        <= 2'd0;
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      ln_config_out <= 5'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < NumPe; i++) begin
              x_snap_q[0][i] <= filter_XID_flat[i*XID_BITS +: XID_BITS];
              x_snap_q[1][i] <= ifmap_XID_flat[i*XID_BITS +: XID_BITS];
              x_snap_q[2][i] <= ipsum_XID_flat[i*XID_BITS +: XID_BITS];
              x_snap_q[3][i] <= opsum_XID_flat[i*XID_BITS +: XID_BITS];
            end
            for (int r = 0; r < NUMS_PE_ROW; r++) begin
              y_snap_q[0][r] <= filter_YID_flat[r*YID_BITS +: YID_BITS];
              y_snap_q[1][r] <= ifmap_YID_flat[r*YID_BITS +: YID_BITS];
              y_snap_q[2][r] <= ipsum_YID_flat[r*YID_BITS +: YID_BITS];
              y_snap_q[3][r] <= opsum_YID_flat[r*YID_BITS +: YID_BITS];
            end
            ln_snap_q <= LN_config_in;
            type_q    <= 2'd0;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            state_q   <= StSendY;
          end
        end
        StSendY: begin
          if (hs) begin
            if (row_q == LastRow) begin
              row_q   <= 3'd0;
              col_q   <= 3'd0;
              state_q <= StSendX;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end
        end
        StSendX: begin
          if (hs) begin
            if (col_q == LastCol) begin
              col_q <= 3'd0;
              if (row_q == LastRow) begin
                row_q <= 3'd0;
                if (type_q == 2'd3) begin
                  // Load the LN register here so its value and strobe appear together.
                  type_q        <= 2'd0;
                  ln_config_out <= ln_snap_q;
                  state_q       <= StLn;
                end else begin
                  type_q  <= type_q + 2'd1;
                  state_q <= StSendY;
                end
              end else begin
                row_q <= row_q + 3'd1;
              end
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
        end
        StLn:    state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
